// File: rtl/imem_pkg.sv
// imem_pkg: shared state encoding, reset PC default and fetch-legality helper
package imem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_e;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  function automatic logic word_legal(input logic [63:0] word, input int unsigned depth);
    return word < 64'(depth);
  endfunction
endpackage

// File: rtl/imem_fetch_sequencer_if.sv
// imem_fetch_sequencer_if: ROM, redirect, decode-handshake and fault signals of the fetch sequencer
interface imem_fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  enable;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_dout;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] fault_pc;
  modport master (
    input  enable, imem_dout, redirect_valid, redirect_pc, instr_ready,
    output imem_addr, instr_valid, instr_data, instr_pc, fault, fault_pc
  );
  modport slave (
    output enable, imem_dout, redirect_valid, redirect_pc, instr_ready,
    input  imem_addr, instr_valid, instr_data, instr_pc, fault, fault_pc
  );
endinterface

// File: rtl/imem_prefetch_fifo.sv
// imem_prefetch_fifo: small synchronous FIFO with flush; read data holds the last head once empty
module imem_prefetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [W-1:0]  last_q, last_d;
  assign count = cnt_q;
  assign full  = cnt_q == (PW+1)'(DEPTH);
  assign rdata = (cnt_q == '0) ? last_q : mem_q[rd_q];
  // pointer/count update; flush wins over push and pop
  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    last_d = rdata;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wdata;
        wr_d = wr_q + PW'(1);
      end
      rd_d  = pop ? rd_q + PW'(1) : rd_q;
      cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // storage and pointer registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
endmodule

// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer: owns the fetch PC, reads the ROM each cycle and feeds decode through a prefetch FIFO
module imem_fetch_sequencer
  import imem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int unsigned           MEM_DEPTH  = 100,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input logic                   clk,
  input logic                   rst_n,
  imem_fetch_sequencer_if.master bus
);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d, fault_pc_q, fault_pc_d;
  logic                    fault_q, fault_d;
  logic                    redir, pop, push, legal, rlegal, full;
  logic [EW-1:0]           head;
  logic [$clog2(FIFO_DEPTH):0] count;
  assign legal  = pc_q[1:0] == 2'b00 && word_legal(64'(pc_q >> 2), MEM_DEPTH);
  assign rlegal = bus.redirect_pc[1:0] == 2'b00 && word_legal(64'(bus.redirect_pc >> 2), MEM_DEPTH);
  assign redir  = bus.redirect_valid && state_q != IDLE;
  assign pop    = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;
  assign push   = state_q == RUN && bus.enable && !redir && legal && (!full || pop);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = count != '0;
  assign {bus.instr_pc, bus.instr_data} = head;
  assign bus.fault       = fault_q;
  assign bus.fault_pc    = fault_pc_q;
  imem_prefetch_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redir),
    .push  (push),
    .pop   (pop),
    .wdata ({pc_q, bus.imem_dout}),
    .rdata (head),
    .full  (full),
    .count (count)
  );
  // next state, PC and fault tracking; redirect has top priority
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    if (redir) begin
      pc_d       = bus.redirect_pc;
      state_d    = rlegal ? RUN : FAULT;
      fault_d    = !rlegal;
      fault_pc_d = rlegal ? '0 : bus.redirect_pc;
    end else if (state_q == IDLE) begin
      state_d = bus.enable ? RUN : IDLE;
    end else if (state_q == RUN && !bus.enable) begin
      state_d = IDLE;
    end else if (state_q == RUN && !legal) begin
      state_d    = FAULT;
      fault_d    = 1'b1;
      fault_pc_d = pc_q;
    end else if (push) begin
      pc_d = pc_q + ADDR_WIDTH'(4);
    end
  end
  // state, PC and fault registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
endmodule

// File: doc/imem_fetch_sequencer.md
Name: imem_fetch_sequencer

Overview:
- Sequences the word-addressed instruction ROM. The ROM is read combinationally from a byte address; internally it indexes word addr>>2.
- Owns the fetch PC and issues one ROM read per cycle.
- Buffers fetched words in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Sits between the instruction ROM and the decode/control stage. It handles branch/jump redirects, flushes and out-of-range faults.

Parameters:
- ADDR_WIDTH, 32, width of the byte address and PC.
- DATA_WIDTH, 32, instruction word width.
- MEM_DEPTH, 100, number of ROM words; the highest legal PC is 4*(MEM_DEPTH-1).
- FIFO_DEPTH, 2, prefetch entries; must be a power of 2 and at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset or enable.

Ports:
- clk  input  1  system clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  start/continue fetching.
- imem_addr  output  ADDR_WIDTH  byte address driven to the ROM.
- imem_dout  input  DATA_WIDTH  ROM read data; combinational, valid in the same cycle as imem_addr.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  ADDR_WIDTH  target byte address.
- instr_valid  output  1  instr_data/instr_pc hold a valid fetched instruction.
- instr_ready  input  1  decode accepts the instruction.
- instr_data  output  DATA_WIDTH  instruction word.
- instr_pc  output  ADDR_WIDTH  byte address of instr_data.
- fault  output  1  sticky fetch fault.
- fault_pc  output  ADDR_WIDTH  address that caused the fault.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State=IDLE, fetch_pc=RESET_PC, FIFO empty.
  - instr_valid=0, instr_data=0, instr_pc=0, fault=0, fault_pc=0.
  - imem_addr=RESET_PC.
- imem_addr = fetch_pc, combinational from the register, in all states.
- States:
  - IDLE: no push. enable=1 -> RUN on the next edge; no fetch in the transition cycle.
  - RUN: fetch as below. enable=0 -> IDLE; fetch_pc is held, the FIFO is retained and keeps draining.
  - FAULT: no push; the FIFO keeps draining. Exit only via a legal redirect (-> RUN) or reset.
- Fetch legality: fetch_pc[1:0]==0 and fetch_pc>>2 < MEM_DEPTH.
- Push (RUN, no redirect, legal, space available):
  - Space available means count<FIFO_DEPTH, or count==FIFO_DEPTH with a pop in the same cycle.
  - Entry {fetch_pc, imem_dout} is written; fetch_pc += 4, modulo 2^ADDR_WIDTH.
- Illegal fetch in RUN without redirect:
  - No push; state -> FAULT; fault=1 and fault_pc=fetch_pc next cycle.
  - Entries already in the FIFO remain deliverable.
- Redirect (redirect_valid=1, any state except IDLE):
  - Takes priority over pop and push in the same cycle.
  - FIFO is flushed; instr_valid=0 next cycle; fetch_pc <= redirect_pc; no push that cycle.
  - If redirect_pc is misaligned or out of range: state -> FAULT, fault=1, fault_pc=redirect_pc.
  - Otherwise: state -> RUN, and fault/fault_pc are cleared.
  - redirect_valid in IDLE is ignored.
- Handshake:
  - instr_valid = FIFO non-empty; instr_data/instr_pc = FIFO head.
  - Pop occurs when instr_valid && instr_ready && !redirect_valid.
  - Head fields are stable while valid && !ready.
  - When the FIFO is empty, instr_data and instr_pc hold their last values.
- Latency: the first instr_valid appears 2 cycles after enable rises (IDLE->RUN edge, then push edge).
- Throughput: one instruction per cycle sustained when instr_ready=1.
- Full FIFO with instr_ready=0: fetch_pc is held; no ROM address advance.
- FIFO pointers: log2(FIFO_DEPTH)-bit wrapping pointers plus a (log2(FIFO_DEPTH)+1)-bit count.
- Simultaneous push+pop leaves count unchanged.

Decomposition:
- Shared package imem_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, FAULT=2'd2;
  - the RESET_PC default;
  - a word-address legality function parameterised by MEM_DEPTH.
- One sub-module: imem_prefetch_fifo, a synchronous FIFO with flush, push/pop, full/empty and count. The top module holds the PC, the state machine and the legality checks.

Test Plan:
- Reset release, enable=1 at cycle 0, instr_ready=1, ROM[0..3]=A0,A1,A2,A3 -> instr_valid rises at cycle 2; instr_pc sequence 0,4,8,C with matching data, one per cycle.
- instr_ready=0 for 5 cycles -> count saturates at 2 and imem_addr holds at 8. Release ready -> PCs 0,4,8 delivered in order with no duplicates or gaps.
- Redirect to 0x40 while the FIFO holds PCs 4 and 8 with instr_ready=1 that cycle -> no pop; next cycle instr_valid=0; following cycle instr_pc=0x40.
- Sequential fetch reaching PC 0x190 with MEM_DEPTH=100:
  - 0x18C is delivered; fault=1 with fault_pc=0x190.
  - No further pushes; instr_valid drops after the drain.
  - A redirect to 0x0 then clears fault and resumes at PC 0.
- Redirect to 0x42 (misaligned) -> fault=1, fault_pc=0x42, FIFO empty, no fetch until the next legal redirect.
- rst_n asserted mid-run with 2 entries buffered -> instr_valid=0 and fault=0 immediately (asynchronous), imem_addr=RESET_PC, state IDLE. After release, no fetch occurs until enable is asserted.
